wd_bus_sequencer: RTL

- Bus master that drives the watchdog_top ABUS/DBUS configuration port.
- Runs the unlock pattern (0xAAAA then 0x5555) and then the four-cycle write window for three operation types: configure, init and service-kick.
- Arbitrates between configure, init, manual kick and periodic auto-kick requests.
- Latches watchdog fault status (WDFAIL, FLSTAT, BROWNOUT) and inhibits kicks while a fault is held.

---
 rtl/wd_bus_sequencer.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wd_bus_sequencer.sv
// Bus master for the watchdog_top ABUS/DBUS configuration port: unlock pattern plus
// four-word write windows for configure, init and kick, with auto-kick and fault latch.
module wd_bus_sequencer #(
    parameter logic [15:0] UNLOCK_A  = 16'hAAAA,
    parameter logic [15:0] UNLOCK_B  = 16'h5555,
    parameter logic [15:0] INIT_WORD = 16'h0010,
    parameter logic [15:0] KICK_WORD = 16'h0001,
    parameter int          PERIOD_W  = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                cfg_req,
    input  logic                init_req,
    input  logic                kick_req,
    input  logic [15:0]         frame_len,
    input  logic [15:0]         svc_len,
    input  logic [15:0]         rst_limit,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] kick_period,
    input  logic                fault_clr,
    input  logic                WDFAIL,
    input  logic [2:0]          FLSTAT,
    input  logic                BROWNOUT,
    output logic [2:0]          ABUS,
    output logic [15:0]         DBUS,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [2:0]          fault_code
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UNLK_A = 2'd1,
        S_UNLK_B = 2'd2,
        S_WR     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_CFG  = 2'd0,
        OP_INIT = 2'd1,
        OP_KICK = 2'd2
    } op_t;

    localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] CNT_ZERO = PERIOD_W'(0);

    state_t              r_state;
    op_t                 r_op;
    logic [1:0]          r_idx;
    logic [15:0]         r_frame;
    logic [15:0]         r_svc;
    logic [15:0]         r_rlim;
    logic                r_cfg_p;
    logic                r_init_p;
    logic                r_kick_p;
    logic                r_armed;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_wdfail_d;

    logic                w_fault_set;
    logic                w_count_en;
    logic                w_auto_fire;
    logic                w_cfg_any;
    logic                w_init_any;
    logic                w_kick_any;
    logic                w_seq_end;
    logic                w_free;
    logic                w_launch_cfg;
    logic                w_launch_init;
    logic                w_launch_kick;
    logic                w_launch_any;
    logic                w_init_done;
    logic                w_kick_done;
    logic [1:0]          w_wr_idx;
    logic [18:0]         w_next_word;

    // Write-window word {ABUS, DBUS} for a given operation and slot index.
    function automatic logic [18:0] wr_word(input op_t op, input logic [1:0] idx,
                                            input logic [15:0] f, input logic [15:0] s,
                                            input logic [15:0] r);
        logic [18:0] w;
        w = {3'b010, 16'h0000};
        case (op)
            OP_CFG: begin
                case (idx)
                    2'd0:    w = {3'b000, f};
                    2'd1:    w = {3'b001, s};
                    2'd2:    w = {3'b011, r};
                    default: w = {3'b010, 16'h0000};
                endcase
            end
            OP_INIT: w = (idx == 2'd0) ? {3'b010, INIT_WORD} : {3'b010, 16'h0000};
            OP_KICK: w = (idx == 2'd0) ? {3'b010, KICK_WORD} : {3'b010, 16'h0000};
            default: w = {3'b000, 16'h0000};
        endcase
        return w;
    endfunction

    // Fault detection, auto-kick expiry, request merging and launch arbitration.
    always_comb begin
        w_fault_set   = ((WDFAIL & ~r_wdfail_d) | BROWNOUT) & (~fault | fault_clr);
        w_count_en    = r_armed & auto_en & ~fault & (kick_period != CNT_ZERO);
        w_auto_fire   = w_count_en & (r_cnt == CNT_ONE);
        w_cfg_any     = r_cfg_p | cfg_req;
        w_init_any    = r_init_p | init_req;
        w_kick_any    = r_kick_p | kick_req | w_auto_fire;
        w_seq_end     = (r_state == S_WR) & (r_idx == 2'd3);
        w_free        = (r_state == S_IDLE) | w_seq_end;
        w_launch_cfg  = w_free & w_cfg_any;
        w_launch_init = w_free & ~w_cfg_any & w_init_any;
        // A held fault blocks only kicks; the kick request stays pending.
        w_launch_kick = w_free & ~w_cfg_any & ~w_init_any & w_kick_any & ~fault;
        w_launch_any  = w_launch_cfg | w_launch_init | w_launch_kick;
        w_init_done   = w_seq_end & (r_op == OP_INIT);
        w_kick_done   = w_seq_end & (r_op == OP_KICK);
    end

    // Next write word: slot 0 after UNLK_B, otherwise the slot after the current one.
    always_comb begin
        if (r_state == S_WR) begin
            w_wr_idx = r_idx + 2'd1;
        end else begin
            w_wr_idx = 2'd0;
        end
        w_next_word = wr_word(r_op, w_wr_idx, r_frame, r_svc, r_rlim);
    end

    // Sequencer FSM with registered bus, busy and done outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_op    <= OP_CFG;
            r_idx   <= 2'd0;
            r_frame <= 16'h0000;
            r_svc   <= 16'h0000;
            r_rlim  <= 16'h0000;
            ABUS    <= 3'b000;
            DBUS    <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= w_seq_end;
            if (w_free) begin
                r_idx <= 2'd0;
                if (w_launch_any) begin
                    r_state <= S_UNLK_A;
                    ABUS    <= 3'b000;
                    DBUS    <= UNLOCK_A;
                    busy    <= 1'b1;
                    if (w_launch_cfg) begin
                        r_op    <= OP_CFG;
                        r_frame <= frame_len;
                        r_svc   <= svc_len;
                        r_rlim  <= rst_limit;
                    end else if (w_launch_init) begin
                        r_op <= OP_INIT;
                    end else begin
                        r_op <= OP_KICK;
                    end
                end else begin
                    r_state <= S_IDLE;
                    ABUS    <= 3'b000;
                    DBUS    <= 16'h0000;
                    busy    <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_UNLK_A: begin
                        r_state <= S_UNLK_B;
                        ABUS    <= 3'b000;
                        DBUS    <= UNLOCK_B;
                    end
                    S_UNLK_B: begin
                        r_state      <= S_WR;
                        r_idx        <= 2'd0;
                        {ABUS, DBUS} <= w_next_word;
                    end
                    S_WR: begin
                        r_idx        <= r_idx + 2'd1;
                        {ABUS, DBUS} <= w_next_word;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        ABUS    <= 3'b000;
                        DBUS    <= 16'h0000;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pending request flags; only the launched one clears.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cfg_p  <= 1'b0;
            r_init_p <= 1'b0;
            r_kick_p <= 1'b0;
        end else begin
            r_cfg_p  <= w_cfg_any & ~w_launch_cfg;
            r_init_p <= w_init_any & ~w_launch_init;
            r_kick_p <= w_kick_any & ~w_launch_kick;
        end
    end

    // Sticky fault latch; a new fault condition beats fault_clr on the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wdfail_d <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 3'b000;
        end else begin
            r_wdfail_d <= WDFAIL;
            if (w_fault_set) begin
                fault      <= 1'b1;
                fault_code <= FLSTAT;
            end else if (fault_clr) begin
                fault      <= 1'b0;
                fault_code <= 3'b000;
            end else begin
                fault      <= fault;
                fault_code <= fault_code;
            end
        end
    end

    // Armed flag and auto-kick down-counter; completed init or kick reloads the period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_armed <= 1'b0;
            r_cnt   <= CNT_ZERO;
        end else begin
            if (w_fault_set) begin
                r_armed <= 1'b0;
            end else if (w_init_done) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= r_armed;
            end
            if (w_init_done | w_kick_done) begin
                r_cnt <= kick_period;
            end else if (w_count_en) begin
                if ((r_cnt == CNT_ONE) || (r_cnt == CNT_ZERO)) begin
                    r_cnt <= kick_period;
                end else begin
                    r_cnt <= r_cnt - CNT_ONE;
                end
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

endmodule
